core_ctrl: RTL and testbench

- Instruction sequencer that sits in front of `core` and drives its 20-bit `inst` bus and `mem_in` bus.
- Runs one complete attention-row job per `start` pulse:
  - load Q rows and K rows from an external valid/ready stream;
  - preload the K weights into the MAC array;
  - stream Q through the array;
  - drain the ofifo into psum memory;
  - run the SFP accumulate pass, then the SFP divide/write-back pass.
- Raises `done` when the job is finished.

---
 rtl/core_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer that runs one attention-row job on `core` per start pulse.
// Optional macro CORE_CTRL_PERF_EN adds a saturating busy-cycle counter output (cycle_cnt).
module core_ctrl #(
    parameter int bw        = 8,
    parameter int pr        = 8,
    parameter int col       = 8,
    parameter int N_Q       = 8,
    parameter int N_K       = 8,
    parameter int DRAIN_CYC = 16,
    parameter int SFP_LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [pr*bw-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [19:0]      inst,
    output logic [pr*bw-1:0] mem_in,
    output logic             busy,
    output logic             done
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [15:0]      cycle_cnt
`endif
);

    if (N_Q < 1 || N_Q > 16 || N_K < 1 || N_K > 16 || DRAIN_CYC < 1 || SFP_LAT < 1 || col < 1)
    begin : g_bad_param
        $error("core_ctrl: parameter out of supported range");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_Q, S_LOAD_K, S_KLOAD, S_EXEC,
        S_DRAIN, S_OFIFO, S_ACC, S_DIV, S_DONE
    } state_t;

    typedef struct packed {
        logic       sfp_wr2pmem;
        logic       sfp_div;
        logic       sfp_acc;
        logic       ofifo_rd;
        logic [3:0] qkmem_add;
        logic [3:0] pmem_add;
        logic       execute;
        logic       kernel_load;
        logic       qmem_rd;
        logic       qmem_wr;
        logic       kmem_rd;
        logic       kmem_wr;
        logic       pmem_rd;
        logic       pmem_wr;
    } inst_t;

    localparam int DIV_LEN  = 2 + SFP_LAT;
    localparam int STEP_MAX = (DRAIN_CYC > DIV_LEN) ? DRAIN_CYC : DIV_LEN;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    localparam logic [4:0]        NQ         = 5'(N_Q);
    localparam logic [4:0]        NK         = 5'(N_K);
    localparam logic [4:0]        LAST_Q     = 5'(N_Q - 1);
    localparam logic [4:0]        LAST_K     = 5'(N_K - 1);
    localparam logic [STEP_W-1:0] LAST_DRAIN = STEP_W'(DRAIN_CYC - 1);
    localparam logic [STEP_W-1:0] LAST_DIV   = STEP_W'(DIV_LEN - 1);

    state_t            state;
    inst_t             inst_q;
    logic [4:0]        row;
    logic [STEP_W-1:0] step;
    logic              accept;

    assign accept = in_valid && in_ready;
    assign inst   = inst_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            row      <= '0;
            step     <= '0;
            inst_q   <= '0;
            mem_in   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: per-cycle outputs default to 0 here so each state only sets its own fields.
            inst_q <= '0;
            mem_in <= '0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD_Q;
                        row      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD_Q: begin
                    if (accept) begin
                        inst_q.qmem_wr   <= 1'b1;
                        inst_q.qkmem_add <= row[3:0];
                        mem_in           <= in_data;
                        if (row == LAST_Q) begin
                            state <= S_LOAD_K;
                            row   <= '0;
                        end else begin
                            row <= row + 5'd1;
                        end
                    end
                end
                S_LOAD_K: begin
                    if (accept) begin
                        inst_q.kmem_wr   <= 1'b1;
                        inst_q.qkmem_add <= row[3:0];
                        mem_in           <= in_data;
                        if (row == LAST_K) begin
                            state    <= S_KLOAD;
                            row      <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            row <= row + 5'd1;
                        end
                    end
                end
                S_KLOAD: begin
                    // The extra trailing cycle lets the last kernel row settle in the array.
                    inst_q.kernel_load <= 1'b1;
                    if (row != NK) begin
                        inst_q.kmem_rd   <= 1'b1;
                        inst_q.qkmem_add <= row[3:0];
                        row              <= row + 5'd1;
                    end else begin
                        state <= S_EXEC;
                        row   <= '0;
                    end
                end
                S_EXEC: begin
                    inst_q.execute <= 1'b1;
                    if (row != NQ) begin
                        inst_q.qmem_rd   <= 1'b1;
                        inst_q.qkmem_add <= row[3:0];
                        row              <= row + 5'd1;
                    end else begin
                        state <= S_DRAIN;
                        step  <= '0;
                    end
                end
                S_DRAIN: begin
                    if (step == LAST_DRAIN) begin
                        state <= S_OFIFO;
                        row   <= '0;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_OFIFO: begin
                    inst_q.ofifo_rd <= 1'b1;
                    inst_q.pmem_wr  <= 1'b1;
                    inst_q.pmem_add <= row[3:0];
                    if (row == LAST_Q) begin
                        state <= S_ACC;
                        row   <= '0;
                    end else begin
                        row <= row + 5'd1;
                    end
                end
                S_ACC: begin
                    // Accumulate trails the psum read by one cycle.
                    if (row != NQ) begin
                        inst_q.pmem_rd  <= 1'b1;
                        inst_q.pmem_add <= row[3:0];
                    end
                    if (row != 5'd0) begin
                        inst_q.sfp_acc <= 1'b1;
                    end
                    if (row == NQ) begin
                        state <= S_DIV;
                        row   <= '0;
                        step  <= '0;
                    end else begin
                        row <= row + 5'd1;
                    end
                end
                S_DIV: begin
                    if (step == '0) begin
                        inst_q.pmem_rd  <= 1'b1;
                        inst_q.pmem_add <= row[3:0];
                    end else if (step == STEP_W'(1)) begin
                        inst_q.sfp_div <= 1'b1;
                    end else if (step == LAST_DIV) begin
                        inst_q.pmem_wr     <= 1'b1;
                        inst_q.sfp_wr2pmem <= 1'b1;
                        inst_q.pmem_add    <= row[3:0];
                    end
                    if (step == LAST_DIV) begin
                        step <= '0;
                        if (row == LAST_Q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            row <= row + 5'd1;
                        end
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CORE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            cycle_cnt <= '0;
        end else if (busy && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: per-cycle expected inst/mem_in scoreboard plus a table of
// job scenarios with hand-computed completion cycles.
module tb_core_ctrl;

    localparam int BW        = 8;
    localparam int PR        = 8;
    localparam int COL       = 8;
    localparam int N_Q       = 8;
    localparam int N_K       = 8;
    localparam int DRAIN_CYC = 16;
    localparam int SFP_LAT   = 1;
    localparam int W         = PR * BW;

    localparam logic [19:0] PMEM_WR  = 20'h00001;
    localparam logic [19:0] PMEM_RD  = 20'h00002;
    localparam logic [19:0] KMEM_WR  = 20'h00004;
    localparam logic [19:0] KMEM_RD  = 20'h00008;
    localparam logic [19:0] QMEM_WR  = 20'h00010;
    localparam logic [19:0] QMEM_RD  = 20'h00020;
    localparam logic [19:0] KLD      = 20'h00040;
    localparam logic [19:0] EXE      = 20'h00080;
    localparam logic [19:0] OFIFO_RD = 20'h10000;
    localparam logic [19:0] SFP_ACC  = 20'h20000;
    localparam logic [19:0] SFP_DIV  = 20'h40000;
    localparam logic [19:0] WR2P     = 20'h80000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [19:0]   inst;
    logic [W-1:0]  mem_in;
    logic          busy;
    logic          done;
`ifdef CORE_CTRL_PERF_EN
    logic [15:0]   cycle_cnt;
`endif

    core_ctrl #(
        .bw(BW), .pr(PR), .col(COL), .N_Q(N_Q), .N_K(N_K),
        .DRAIN_CYC(DRAIN_CYC), .SFP_LAT(SFP_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .mem_in   (mem_in),
        .busy     (busy),
        .done     (done)
`ifdef CORE_CTRL_PERF_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0]  inst;
        logic [W-1:0] data;
        bit           has_data;
    } exp_t;

    typedef struct {
        int           mode;
        logic [W-1:0] mask;
        int           exp_done;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [19:0] qk(input int a);
        return 20'(a) << 12;
    endfunction

    function automatic logic [19:0] pm(input int a);
        return 20'(a) << 8;
    endfunction

    function automatic logic [W-1:0] junk();
        return {$urandom, $urandom};
    endfunction

    // Q row b is {8{b+1}} (0101..0808); K row b is {8{80+b}}; both xor'd with a per-job mask.
    function automatic logic [W-1:0] row_data(input int b, input logic [W-1:0] mask);
        logic [7:0] byte_v;
        byte_v = (b < N_Q) ? 8'(b + 1) : 8'(8'h80 + b - N_Q);
        return {PR{byte_v}} ^ mask;
    endfunction

    function automatic void push(input logic [19:0] i, input logic [W-1:0] d, input bit hd);
        exp_t e;
        e.inst     = i;
        e.data     = d;
        e.has_data = hd;
        sb.push_back(e);
    endfunction

    // Expected inst words for every cycle from the first kernel-load word to the last write-back.
    function automatic int push_tail();
        int n0;
        logic [19:0] v;
        n0 = sb.size();
        for (int k = 0; k <= N_K; k++)
            push(KLD | ((k < N_K) ? (KMEM_RD | qk(k)) : 20'h0), '0, 1'b0);
        for (int k = 0; k <= N_Q; k++)
            push(EXE | ((k < N_Q) ? (QMEM_RD | qk(k)) : 20'h0), '0, 1'b0);
        for (int k = 0; k < DRAIN_CYC; k++)
            push(20'h0, '0, 1'b0);
        for (int k = 0; k < N_Q; k++)
            push(OFIFO_RD | PMEM_WR | pm(k), '0, 1'b0);
        for (int k = 0; k <= N_Q; k++) begin
            v = 20'h0;
            if (k < N_Q) v = v | PMEM_RD | pm(k);
            if (k >= 1)  v = v | SFP_ACC;
            push(v, '0, 1'b0);
        end
        for (int r = 0; r < N_Q; r++) begin
            push(PMEM_RD | pm(r), '0, 1'b0);
            push(SFP_DIV, '0, 1'b0);
            for (int k = 0; k < SFP_LAT - 1; k++)
                push(20'h0, '0, 1'b0);
            push(PMEM_WR | WR2P | pm(r), '0, 1'b0);
        end
        return sb.size() - n0;
    endfunction

    // mode 0: in_valid always high; 1: toggles (low first) during Q load; 2: toggles through both loads.
    task automatic run_job(input int mode, input logic [W-1:0] mask, input int exp_done,
                           input bit hold_start, input int abort_cyc);
        exp_t e;
        int   beats;
        int   done_cyc;
        int   done_seen;
        int   tail;
        bit   tog;
        bit   v;
        bit   finished;
        sb.delete();
        beats     = 0;
        done_cyc  = -1;
        done_seen = -1;
        tog       = 1'b0;
        finished  = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = junk();
        @(posedge clk);
        cyc = 0;
        push(20'h0, '0, 1'b0);
        for (int n = 0; n < 400 && !finished; n++) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
            if (sb.size() == 0) begin
                finished = 1'b1;
                check("restart_busy", 64'(busy), 64'(hold_start));
                check("restart_ready", 64'(in_ready), 64'(hold_start));
            end else begin
                e = sb.pop_front();
                check("inst", 64'(inst), 64'(e.inst));
                if (e.has_data) check("mem_in", 64'(mem_in), 64'(e.data));
                check("rdwr_excl", 64'({inst[1] & inst[0], (inst[5] | inst[3]) & (inst[4] | inst[2])}), 64'h0);
                check("busy", 64'(busy), 64'(done_cyc < 0 || cyc <= done_cyc));
                check("done", 64'(done), 64'(cyc == done_cyc));
                check("in_ready", 64'(in_ready), 64'(beats < N_Q + N_K));
                if (done === 1'b1 && done_seen < 0) done_seen = cyc;
                if (cyc == abort_cyc) begin
                    reset = 1'b0;
                    #1;
                    check("abort_inst", 64'(inst), 64'h0);
                    check("abort_mem_in", 64'(mem_in), 64'h0);
                    check("abort_busy", 64'(busy), 64'h0);
                    check("abort_done", 64'(done), 64'h0);
                    check("abort_ready", 64'(in_ready), 64'h0);
                    @(negedge clk);
                    reset = 1'b1;
                    start = 1'b0;
                    sb.delete();
                    return;
                end
                if (beats < N_Q + N_K) begin
                    v   = (mode == 0) || (mode == 1 && beats >= N_Q) ? 1'b1 : tog;
                    tog = !tog;
                    in_valid = v;
                    in_data  = v ? row_data(beats, mask) : junk();
                    if (v) begin
                        push((beats < N_Q) ? (QMEM_WR | qk(beats)) : (KMEM_WR | qk(beats - N_Q)),
                             row_data(beats, mask), 1'b1);
                        beats++;
                        if (beats == N_Q + N_K) begin
                            tail     = push_tail();
                            done_cyc = cyc + 1 + tail;
                            push(20'h0, '0, 1'b0);
                        end
                    end else begin
                        push(20'h0, '0, 1'b0);
                    end
                end else begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = junk();
                end
            end
        end
        check("job_finished", 64'(finished), 64'h1);
        check("done_cycle", 64'(done_seen), 64'(exp_done));
`ifdef CORE_CTRL_PERF_EN
        if (!hold_start) check("cycle_cnt", 64'(cycle_cnt), 64'(exp_done));
`endif
        start = 1'b0;
    endtask

    initial begin
        vec_t vecs[3];
        vecs[0].mode = 0; vecs[0].mask = '0;           vecs[0].exp_done = 92;
        vecs[1].mode = 1; vecs[1].mask = {8{8'h5a}};   vecs[1].exp_done = 100;
        vecs[2].mode = 2; vecs[2].mask = {8{8'hff}};   vecs[2].exp_done = 108;

        // Reset held with start and in_valid asserted: everything stays quiet.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = junk();
        #1;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            cyc = n;
            check("rst_inst", 64'(inst), 64'h0);
            check("rst_mem_in", 64'(mem_in), 64'h0);
            check("rst_ready", 64'(in_ready), 64'h0);
            check("rst_busy", 64'(busy), 64'h0);
            check("rst_done", 64'(done), 64'h0);
        end
        start = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            cyc = 10 + n;
            check("idle_inst", 64'(inst), 64'h0);
            check("idle_ready", 64'(in_ready), 64'h0);
            check("idle_busy", 64'(busy), 64'h0);
        end

        for (int t = 0; t < 3; t++)
            run_job(vecs[t].mode, vecs[t].mask, vecs[t].exp_done, 1'b0, -1);

        // start held high through DONE: exactly one IDLE cycle, then a new job.
        run_job(0, {8{8'h3c}}, 92, 1'b1, -1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'h0);

        // Reset mid-DIV (row 4), then a fresh job must start again from address 0.
        run_job(0, '0, 92, 1'b0, 82);
        run_job(0, '0, 92, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
